ofs_plat_local_mem_avalon_responder: RTL



---
 rtl/local_mem_cfg_pkg.sv | 15 +
 rtl/ofs_plat_local_mem_avalon_mem_pkg.sv | 13 +
 rtl/ofs_plat_local_mem_responder_rd_pipe.sv | 46 ++++
 rtl/ofs_plat_local_mem_avalon_responder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/local_mem_cfg_pkg.sv
// Platform-level local memory geometry and the line-sized types built from it.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package local_mem_cfg_pkg;

  localparam int LOCAL_MEM_ADDR_WIDTH      = 27;
  localparam int LOCAL_MEM_DATA_WIDTH      = 512;
  localparam int LOCAL_MEM_BURST_CNT_WIDTH = 7;

  typedef logic [LOCAL_MEM_ADDR_WIDTH-1:0]      t_local_mem_addr;
  typedef logic [LOCAL_MEM_DATA_WIDTH-1:0]      t_local_mem_data;
  typedef logic [LOCAL_MEM_BURST_CNT_WIDTH-1:0] t_local_mem_burst_cnt;
  typedef logic [LOCAL_MEM_DATA_WIDTH/8-1:0]    t_local_mem_byte_mask;

endpackage

// File: rtl/ofs_plat_local_mem_avalon_mem_pkg.sv
// Shared types for the emulated Avalon local memory bank.
// Latency: none (types only).
// Backpressure: not applicable.
package ofs_plat_local_mem_avalon_mem_pkg;

  // Command sequencing: idle, collecting write beats, or issuing read beats.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } t_lm_responder_state;

endpackage

// File: rtl/ofs_plat_local_mem_responder_rd_pipe.sv
// Read return pipe: delays each issued read beat and its array data by LATENCY cycles.
// Latency: exactly LATENCY cycles from in_vld to out_vld, one beat per cycle.
// Backpressure: none; the consumer must take every beat as it emerges.
module ofs_plat_local_mem_responder_rd_pipe #(
  parameter int DATA_WIDTH = 512,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat
);

  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];
  logic [DATA_WIDTH-1:0] dat_d [LATENCY];

  // Shift one stage per cycle; idle slots carry zero data so the output is clean between beats.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    for (int i = LATENCY - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    vld_d[0] = in_vld;
    dat_d[0] = in_vld ? in_dat : '0;
  end

  // Pipeline registers; reset drops every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/ofs_plat_local_mem_avalon_responder.sv
// Avalon-MM bank emulator: burst reads/writes against an on-chip line array.
// Latency: READ_LATENCY cycles from read beat issue to readdatavalid; writes visible next cycle.
// Backpressure: waitrequest high in reset's first cycle out and while a read burst issues beats.
module ofs_plat_local_mem_avalon_responder #(
  parameter int ADDR_WIDTH      = local_mem_cfg_pkg::LOCAL_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = local_mem_cfg_pkg::LOCAL_MEM_DATA_WIDTH,
  parameter int BURST_CNT_WIDTH = local_mem_cfg_pkg::LOCAL_MEM_BURST_CNT_WIDTH,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       avs_waitrequest,
  input  logic [ADDR_WIDTH-1:0]      avs_address,
  input  logic [BURST_CNT_WIDTH-1:0] avs_burstcount,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [DATA_WIDTH-1:0]      avs_writedata,
  input  logic [DATA_WIDTH/8-1:0]    avs_byteenable,
  output logic [DATA_WIDTH-1:0]      avs_readdata,
  output logic                       avs_readdatavalid,
  output logic                       protocol_error
);
  import ofs_plat_local_mem_avalon_mem_pkg::*;

  localparam int NBYTES = DATA_WIDTH / 8;

  t_lm_responder_state        state_q, state_d;
  logic [BURST_CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]      next_addr_q, next_addr_d;
  logic                       perr_q, perr_d;
  logic                       live_q, live_d;

  logic                       wr_en;
  logic                       rd_issue;
  logic [ADDR_WIDTH-1:0]      acc_addr;
  logic [MEM_DEPTH_LOG2-1:0]  acc_idx;
  logic [DATA_WIDTH-1:0]      rd_dat;
  logic [DATA_WIDTH-1:0]      mem [1 << MEM_DEPTH_LOG2];

  // live_q holds off commands for the first cycle after reset release.
  assign avs_waitrequest = !live_q || (state_q == RD_BURST);
  assign protocol_error  = perr_q;

  // Command decode and burst sequencing; reads and writes never share a cycle, so one index serves both.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    next_addr_d = next_addr_q;
    perr_d      = perr_q;
    live_d      = 1'b1;
    wr_en       = 1'b0;
    rd_issue    = 1'b0;
    acc_addr    = next_addr_q;
    case (state_q)
      IDLE: begin
        if (live_q && (avs_read || avs_write)) begin
          acc_addr = avs_address;
          wr_en    = avs_write;
          rd_issue = !avs_write;
          // Zero-length bursts run as one beat; a read alongside a write is dropped.
          if ((avs_read && avs_write) || (avs_burstcount == '0)) perr_d = 1'b1;
          if (avs_burstcount > BURST_CNT_WIDTH'(1)) begin
            remaining_d = avs_burstcount - BURST_CNT_WIDTH'(1);
            next_addr_d = avs_address + ADDR_WIDTH'(1);
            state_d     = avs_write ? WR_BURST : RD_BURST;
          end
        end
      end
      WR_BURST: begin
        if (avs_read) perr_d = 1'b1;
        if (avs_write) begin
          wr_en       = 1'b1;
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - BURST_CNT_WIDTH'(1);
          if (remaining_q == BURST_CNT_WIDTH'(1)) state_d = IDLE;
        end
      end
      RD_BURST: begin
        rd_issue    = 1'b1;
        next_addr_d = next_addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - BURST_CNT_WIDTH'(1);
        if (remaining_q == BURST_CNT_WIDTH'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; the array itself is deliberately left out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      next_addr_q <= '0;
      perr_q      <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      next_addr_q <= next_addr_d;
      perr_q      <= perr_d;
      live_q      <= live_d;
    end
  end

  // Index wraps at the array depth, so high address bits alias.
  assign acc_idx = acc_addr[MEM_DEPTH_LOG2-1:0];
  assign rd_dat  = mem[acc_idx];

  // Byte-masked line write; disabled bytes keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (avs_byteenable[b]) mem[acc_idx][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

  ofs_plat_local_mem_responder_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (reset),
    .in_vld  (rd_issue),
    .in_dat  (rd_dat),
    .out_vld (avs_readdatavalid),
    .out_dat (avs_readdata)
  );

endmodule
